// File: rtl/layer_seq_ctrl_if.sv
// layer_seq_ctrl_if: input/output handshake bundle for layer_seq_ctrl.
// The master drives vectors and accepts results; the slave is the sequencer.
interface layer_seq_ctrl_if #(
    parameter int NUM_NEURONS = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [6*NUM_NEURONS-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_NEURONS-1:0]   out_data;
    logic                     busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: evaluates NUM_NEURONS 6-input LUT neurons one per cycle on a
// latched feature vector, then holds the result until the consumer takes it.
// Optional feature macro: LUT_RELOAD_EN adds a runtime table-write port
// (cfg_we/cfg_sel/cfg_table/cfg_err); without it the tables are TABLE_INIT.
module layer_seq_ctrl #(
    parameter int                        NUM_NEURONS = 4,
    parameter logic [64*NUM_NEURONS-1:0] TABLE_INIT  = '0,
    localparam int                       IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    layer_seq_ctrl_if.slave    bus
`ifdef LUT_RELOAD_EN
    ,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_sel,
    input  logic [63:0]        cfg_table,
    output logic               cfg_err
`endif
);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q;
    logic [6*NUM_NEURONS-1:0]        data_p0;
    logic [NUM_NEURONS-1:0]          out_q;
    logic [NUM_NEURONS-1:0][63:0]    tables;
    logic [5:0]                      addr;
    logic                            accept;
    logic                            last;

    // One truth-table lookup: address bit i comes from slice bit i.
    function automatic logic lut_lookup(input logic [63:0] t, input logic [5:0] a);
        return t[a];
    endfunction

    assign accept = (state_q == IDLE) && bus.in_valid;
    assign last   = (idx_q == IDX_W'(NUM_NEURONS - 1));

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_data  = out_q;

    // Select the 6-bit input slice of the neuron currently being evaluated.
    always_comb begin
        addr = data_p0[6*idx_q +: 6];
    end

    // Next-state logic; DONE->IDLE never accepts, so in_ready rises a cycle later.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = EVAL;
            EVAL:    if (last)         state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Neuron index and result bits; untouched bits keep their previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            out_q <= '0;
        end else if (accept) begin
            idx_q <= '0;
        end else if (state_q == EVAL) begin
            out_q[idx_q] <= lut_lookup(tables[idx_q], addr);
            idx_q        <= last ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Feature vector capture at acceptance; later in_data changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) data_p0 <= bus.in_data;
    end

`ifdef LUT_RELOAD_EN
    logic sel_ok;
    logic cfg_err_q;

    assign sel_ok  = (int'(cfg_sel) < NUM_NEURONS);
    assign cfg_err = cfg_err_q;

    // Table storage: reload only in IDLE with a valid selector, else flag an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tables    <= TABLE_INIT;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we && !((state_q == IDLE) && sel_ok);
            if (cfg_we && (state_q == IDLE) && sel_ok) tables[cfg_sel] <= cfg_table;
        end
    end
`else
    assign tables = TABLE_INIT;
`endif

endmodule
